// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-side signals of the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 42
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_wr_ready;

  modport master (
    input  req,
    input  req_data,
    input  fifo_wr_ready,
    output gnt,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport slave (
    output req,
    output req_data,
    output fifo_wr_ready,
    input  gnt,
    input  fifo_wr_en,
    input  fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-side arbiter for the single-entry async FIFO
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 42,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus,
  output logic              busy,
  output logic [15:0]       wr_count
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BLK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, BLANK} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready_s;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_n;
  logic [BLK_W-1:0]       blank_cnt, blank_cnt_n;
  logic [NUM_REQ-1:0]     gnt_q, gnt_n;
  logic                   wr_en_q, wr_en_n;
  logic [DATA_W-1:0]      data_q, data_n;
  logic [15:0]            wr_count_n;
  logic                   busy_n;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;

  assign bus.gnt          = gnt_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = data_q;
  assign ready_s          = sync_q[SYNC_STAGES-1];

  // Bring the FIFO's asynchronous wr_ready into clk; reset makes the FIFO look not ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.fifo_wr_ready};
    end
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Next-state and next-output logic; BLANK deliberately ignores ready_s so a stale ready cannot double-write
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    blank_cnt_n = blank_cnt;
    gnt_n       = '0;
    wr_en_n     = 1'b0;
    data_n      = data_q;
    wr_count_n  = wr_count;
    case (state)
      IDLE: begin
        if (ready_s && win_found) begin
          data_n   = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
          gnt_n    = NUM_REQ'(1) << win_idx;
          wr_en_n  = 1'b1;
          rr_ptr_n = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          state_n  = WRITE;
        end
      end
      WRITE: begin
        wr_count_n  = wr_count + 16'd1;
        blank_cnt_n = BLANK_LOAD;
        state_n     = BLANK;
      end
      BLANK: begin
        if (blank_cnt <= BLK_W'(1)) begin
          blank_cnt_n = '0;
          state_n     = IDLE;
        end else begin
          blank_cnt_n = blank_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; async reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      blank_cnt <= '0;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      wr_count  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      blank_cnt <= blank_cnt_n;
      gnt_q     <= gnt_n;
      wr_en_q   <= wr_en_n;
      data_q    <= data_n;
      wr_count  <= wr_count_n;
      busy      <= busy_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    int         exp_gap;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] wr_count;

  logic        full = 1'b0;
  logic        drain_en;
  logic        stale;
  int          overwrites = 0;

  logic [41:0] pay [4];
  vec_t        vecs [11];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          gap;
  logic [3:0]  g;
  logic [3:0]  seen_gnt;
  logic        seen_wr_en;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(42)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  // Single-entry FIFO model: a write fills the slot, the reader empties it one edge later when enabled
  assign bus.fifo_wr_ready = stale | ~full;

  always @(posedge clk) begin
    if (bus.fifo_wr_en && full && !stale) overwrites <= overwrites + 1;
    if (bus.fifo_wr_en) full <= 1'b1;
    else if (drain_en) full <= 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input int budget, output int gp, output logic [3:0] gg);
    gp = 0;
    gg = '0;
    while (gp < budget) begin
      @(negedge clk);
      gp++;
      if (bus.gnt != 4'b0) begin
        gg = bus.gnt;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clk);
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pay[0] = 42'h2AA_AAAA_AAAA;
    pay[1] = 42'h155_5555_5555;
    pay[2] = 42'h3FF_0000_FFFF;
    pay[3] = 42'h000_DEAD_BEEF;
    bus.req_data = {pay[3], pay[2], pay[1], pay[0]};
    bus.req  = 4'b0000;
    stale    = 1'b0;
    drain_en = 1'b1;
    rst_n    = 1'b0;

    // Round-robin expectations; rr_ptr is 1 after the first write to requester 0
    vecs[0]  = '{4'b1111, 4'b0010, 1};
    vecs[1]  = '{4'b1111, 4'b0100, 5};
    vecs[2]  = '{4'b1111, 4'b1000, 5};
    vecs[3]  = '{4'b1111, 4'b0001, 5};
    vecs[4]  = '{4'b1111, 4'b0010, 5};
    vecs[5]  = '{4'b1010, 4'b1000, 5};
    vecs[6]  = '{4'b1010, 4'b0010, 5};
    vecs[7]  = '{4'b0101, 4'b0100, 5};
    vecs[8]  = '{4'b0001, 4'b0001, 5};
    vecs[9]  = '{4'b1000, 4'b1000, 5};
    vecs[10] = '{4'b1001, 4'b0001, 5};

    repeat (2) @(negedge clk);
    check("rst_gnt", {60'd0, bus.gnt}, 64'd0);
    check("rst_wr_en", {63'd0, bus.fifo_wr_en}, 64'd0);
    check("rst_data", {22'd0, bus.fifo_wr_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_count", {48'd0, wr_count}, 64'd0);

    // First write after reset: 2 synchronizer cycles, then the grant
    bus.req = 4'b0001;
    rst_n   = 1'b1;
    wait_gnt(10, gap, g);
    check("t1_gap", 64'(gap), 64'd3);
    check("t1_gnt", {60'd0, g}, 64'h1);
    check("t1_wr_en", {63'd0, bus.fifo_wr_en}, 64'd1);
    check("t1_data", {22'd0, bus.fifo_wr_data}, {22'd0, pay[0]});
    check("t1_busy", {63'd0, busy}, 64'd1);
    bus.req = 4'b0000;
    @(negedge clk);
    check("t1_wr_en_off", {63'd0, bus.fifo_wr_en}, 64'd0);
    check("t1_gnt_off", {60'd0, bus.gnt}, 64'd0);
    check("t1_count", {48'd0, wr_count}, 64'd1);
    check("t1_data_hold", {22'd0, bus.fifo_wr_data}, {22'd0, pay[0]});

    // Table-driven round-robin sequence with the reader draining after each write
    wait_idle();
    for (int i = 0; i < 11; i++) begin
      bus.req = vecs[i].req;
      wait_gnt(12, gap, g);
      check($sformatf("row%0d_gap", i), 64'(gap), 64'(vecs[i].exp_gap));
      check($sformatf("row%0d_gnt", i), {60'd0, g}, {60'd0, vecs[i].exp_gnt});
      check($sformatf("row%0d_data", i), {22'd0, bus.fifo_wr_data}, {22'd0, pay[oh2idx(vecs[i].exp_gnt)]});
      check($sformatf("row%0d_wr_en", i), {63'd0, bus.fifo_wr_en}, 64'd1);
    end
    bus.req = 4'b0000;
    wait_idle();
    check("table_count", {48'd0, wr_count}, 64'd12);

    // Stale ready held high through BLANK: next write only after the full blanking window
    stale   = 1'b1;
    bus.req = 4'b0100;
    wait_gnt(12, gap, g);
    check("stale_first_gnt", {60'd0, g}, 64'h4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) check($sformatf("stale_hold%0d", k), {63'd0, bus.fifo_wr_en}, 64'd0);
      else check("stale_second_wr_en", {63'd0, bus.fifo_wr_en}, 64'd1);
    end
    bus.req = 4'b0000;
    stale   = 1'b0;
    wait_idle();
    check("stale_count", {48'd0, wr_count}, 64'd14);

    // Fill the slot with the reader stalled (rr_ptr=3, so requester 0 wins)
    drain_en = 1'b0;
    bus.req  = 4'b0001;
    wait_gnt(12, gap, g);
    check("fill_gnt", {60'd0, g}, 64'h1);
    bus.req = 4'b0000;
    wait_idle();

    // Withdrawal while full: requester 1 drops its request before any grant
    seen_gnt   = '0;
    seen_wr_en = 1'b0;
    bus.req    = 4'b0010;
    repeat (6) begin
      @(negedge clk);
      seen_gnt   = seen_gnt | bus.gnt;
      seen_wr_en = seen_wr_en | bus.fifo_wr_en;
    end
    bus.req = 4'b0000;
    repeat (6) begin
      @(negedge clk);
      seen_gnt   = seen_gnt | bus.gnt;
      seen_wr_en = seen_wr_en | bus.fifo_wr_en;
    end
    check("wd_gnt", {60'd0, seen_gnt}, 64'd0);
    check("wd_wr_en", {63'd0, seen_wr_en}, 64'd0);
    check("wd_count", {48'd0, wr_count}, 64'd15);

    // Pending request against a full FIFO stays parked in IDLE
    bus.req = 4'b0100;
    repeat (10) begin
      @(negedge clk);
      seen_gnt   = seen_gnt | bus.gnt;
      seen_wr_en = seen_wr_en | bus.fifo_wr_en;
    end
    check("full_gnt", {60'd0, seen_gnt}, 64'd0);
    check("full_wr_en", {63'd0, seen_wr_en}, 64'd0);
    check("full_busy", {63'd0, busy}, 64'd0);

    // Release reader: ready rises at the next edge, grant 3 edges later (4th negedge from here)
    drain_en = 1'b1;
    wait_gnt(10, gap, g);
    check("release_gap", 64'(gap), 64'd4);
    check("release_gnt", {60'd0, g}, 64'h4);
    check("release_data", {22'd0, bus.fifo_wr_data}, {22'd0, pay[2]});

    // Reset asserted while in WRITE (rr_ptr=3 here); outputs must clear without a clock edge
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", {63'd0, bus.fifo_wr_en}, 64'd0);
    check("mid_rst_gnt", {60'd0, bus.gnt}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_count", {48'd0, wr_count}, 64'd0);
    check("mid_rst_data", {22'd0, bus.fifo_wr_data}, 64'd0);
    @(negedge clk);
    bus.req = 4'b1001;
    rst_n   = 1'b1;
    wait_gnt(10, gap, g);
    check("post_rst_gap", 64'(gap), 64'd3);
    check("post_rst_gnt", {60'd0, g}, 64'h1);
    check("post_rst_data", {22'd0, bus.fifo_wr_data}, {22'd0, pay[0]});
    bus.req = 4'b0000;
    wait_idle();
    check("post_rst_count", {48'd0, wr_count}, 64'd1);
    check("no_overwrite", 64'(overwrites), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
